// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-memory access unit.
// Runs a req/ack transaction with data memory and returns aligned, extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        busywait,
    output logic        access_fault,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int unsigned      TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane;
    logic [2:0]       f3_q;

    logic        access;
    logic        is_store;
    logic        illegal;
    logic        misaligned;
    logic        in_idle;
    logic        legal_access;
    logic        timeout_hit;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext_data;

    // A simultaneous read+write request is treated as a store.
    always_comb begin
        access     = mem_read | mem_write;
        is_store   = mem_write;
        if (is_store)
            illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        else
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        in_idle      = (state == IDLE);
        access_fault = in_idle & access & (misaligned | illegal);
        legal_access = in_idle & access & ~(misaligned | illegal);
        busywait     = legal_access | (state == WAIT);
        timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                fmt_wdata = {4{store_data[7:0]}};
                fmt_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{store_data[15:0]}};
                fmt_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_wdata = store_data;
                fmt_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane selection uses the offset captured at request time, not the live address.
    always_comb begin
        case (lane)
            2'b00:   rbyte = mem_rdata[7:0];
            2'b01:   rbyte = mem_rdata[15:8];
            2'b10:   rbyte = mem_rdata[23:16];
            default: rbyte = mem_rdata[31:24];
        endcase
        rhalf = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext_data = {24'h000000, rbyte};
            3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext_data = {16'h0000, rhalf};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lane      <= 2'b00;
            f3_q      <= 3'b000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            load_data <= 32'h0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_access) begin
                        state     <= WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= is_store ? fmt_wdata : 32'h0;
                        mem_wstrb <= is_store ? fmt_wstrb : 4'b0000;
                        lane      <= addr[1:0];
                        f3_q      <= funct3;
                        cnt       <= '0;
                    end
                end
                WAIT: begin
                    // An ack arriving on the last allowed cycle still wins over the abort.
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (!mem_we)
                            load_data <= ext_data;
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        load_data <= 32'h0;
                        bus_error <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit against a transaction-level model.
// Inputs change on the falling edge; outputs are compared just before each rising edge.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] load_data;
    logic        busywait;
    logic        access_fault;
    logic        bus_error;

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .load_data(load_data), .busywait(busywait),
        .access_fault(access_fault), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Model state: one outstanding transaction plus a one-cycle "finishing" slot.
    bit          m_pend = 1'b0;
    bit          m_fin = 1'b0;
    bit          m_isload = 1'b0;
    bit          m_req = 1'b0;
    bit          m_we = 1'b0;
    bit          m_berr = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_ld = 32'h0;
    logic [3:0]  m_wstrb = 4'h0;
    logic [2:0]  m_f3 = 3'b000;
    int unsigned m_off = 0;
    int unsigned m_waited = 0;

    // Observations captured by runAccess for the literal checks.
    bit          obs_we, obs_fault, obs_berr;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_wstrb;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isFault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        int unsigned nb;
        if (wr) ok = (f3 <= 3'd2);
        else    ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        nb = 32'd1 << f3[1:0];
        return !ok || ((a % nb) != 0);
    endfunction

    function automatic logic [3:0] storeStrb(input logic [2:0] f3, input int unsigned off);
        int unsigned nb;
        logic [3:0] s;
        nb = 32'd1 << f3[1:0];
        s  = 4'((32'd1 << nb) - 32'd1);
        return s << off;
    endfunction

    function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'b00) return {24'h0, sd[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return {16'h0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input int unsigned off, input logic [2:0] f3);
        int unsigned nb, sh;
        logic [31:0] mask, v;
        nb   = 32'd1 << f3[1:0];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        sh   = (nb == 1) ? 8 * off : (nb == 2) ? 8 * (off & 2) : 0;
        v    = (w >> sh) & mask;
        if (!f3[2] && nb != 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_fin = 0; m_isload = 0; m_req = 0; m_we = 0; m_berr = 0;
            m_addr = 0; m_wdata = 0; m_ld = 0; m_wstrb = 0; m_f3 = 0; m_off = 0; m_waited = 0;
        end else begin
            m_berr = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (m_pend) begin
                if (mem_ack) begin
                    m_pend = 0; m_fin = 1; m_req = 0; m_we = 0; m_wstrb = 0;
                    if (m_isload) m_ld = extract(mem_rdata, m_off, m_f3);
                end else if (TIMEOUT != 0 && m_waited + 1 == TIMEOUT) begin
                    m_pend = 0; m_fin = 1; m_req = 0; m_ld = 0; m_berr = 1;
                end else begin
                    m_waited++;
                end
            end else if ((mem_read || mem_write) && !isFault(mem_write, funct3, addr)) begin
                m_pend   = 1;
                m_waited = 0;
                m_req    = 1;
                m_isload = !mem_write;
                m_we     = mem_write;
                m_addr   = addr & ~32'h3;
                m_off    = addr % 4;
                m_f3     = funct3;
                m_wstrb  = mem_write ? storeStrb(funct3, m_off) : 4'h0;
                m_wdata  = mem_write ? storeData(funct3, store_data) : 32'h0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit idle, acc, flt;
        #4;
        if (started) begin
            idle = !m_pend && !m_fin;
            acc  = mem_read || mem_write;
            flt  = isFault(mem_write, funct3, addr);
            checkOutput("mem_req", {31'h0, mem_req}, {31'h0, m_req});
            checkOutput("mem_we", {31'h0, mem_we}, {31'h0, m_we});
            checkOutput("mem_addr", mem_addr, m_addr);
            checkOutput("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m_wstrb});
            if (m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
            checkOutput("load_data", load_data, m_ld);
            checkOutput("bus_error", {31'h0, bus_error}, {31'h0, m_berr});
            checkOutput("busywait", {31'h0, busywait}, {31'h0, (idle && acc && !flt) || m_pend});
            checkOutput("access_fault", {31'h0, access_fault}, {31'h0, idle && acc && flt});
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    // Plays memory for one access; ack_after = 0 never acknowledges.
    task automatic runAccess(input int ack_after, input logic [31:0] rdata,
                             output int busy, output int reqc);
        bit ended;
        busy  = 0;
        reqc  = 0;
        ended = 0;
        for (int c = 0; c < 64; c++) begin
            if (mem_req) begin
                reqc++;
                if (reqc == 1) begin
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end
                if (ack_after != 0 && reqc == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            #2;
            if (c == 0) obs_fault = access_fault;
            if (busywait) begin
                busy++;
            end else begin
                obs_ld   = load_data;
                obs_berr = bus_error;
                ended    = 1;
                break;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        if (!ended) checkOutput("access_bound", 32'h0, 32'h1);
    endtask

    initial begin
        int busy, reqc;
        repeat (2) @(negedge clk);
        started = 1'b1;
        #2;
        checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("reset_load_data", load_data, 32'h0);
        checkOutput("reset_busywait", {31'h0, busywait}, 32'h0);
        rst = 1'b1;

        applyStimulus(1, 0, 3'b000, 32'h0000_1003, 32'h0);
        runAccess(1, 32'h80FF_1234, busy, reqc);
        checkOutput("lb_addr", obs_addr, 32'h0000_1000);
        checkOutput("lb_wstrb", {28'h0, obs_wstrb}, 32'h0);
        checkOutput("lb_data", obs_ld, 32'hFFFF_FF80);
        checkOutput("lb_busy", busy, 2);

        applyStimulus(1, 0, 3'b100, 32'h0000_1003, 32'h0);
        runAccess(1, 32'h80FF_1234, busy, reqc);
        checkOutput("lbu_data", obs_ld, 32'h0000_0080);

        applyStimulus(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
        runAccess(3, 32'h0, busy, reqc);
        checkOutput("sh_we", {31'h0, obs_we}, 32'h1);
        checkOutput("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        checkOutput("sh_wstrb", {28'h0, obs_wstrb}, 32'hC);
        checkOutput("sh_busy", busy, 4);
        checkOutput("sh_load_kept", obs_ld, 32'h0000_0080);

        applyStimulus(1, 0, 3'b010, 32'h0000_1001, 32'h0);
        runAccess(1, 32'h0, busy, reqc);
        checkOutput("lw_mis_fault", {31'h0, obs_fault}, 32'h1);
        checkOutput("lw_mis_busy", busy, 0);
        checkOutput("lw_mis_req", reqc, 0);

        applyStimulus(1, 0, 3'b011, 32'h0000_1000, 32'h0);
        runAccess(1, 32'h0, busy, reqc);
        checkOutput("f3_011_fault", {31'h0, obs_fault}, 32'h1);
        checkOutput("f3_011_req", reqc, 0);

        applyStimulus(0, 1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF);
        runAccess(1, 32'h0, busy, reqc);
        checkOutput("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        checkOutput("sw_wstrb", {28'h0, obs_wstrb}, 32'hF);
        applyStimulus(1, 0, 3'b010, 32'h0000_3000, 32'h0);
        runAccess(2, 32'hDEAD_BEEF, busy, reqc);
        checkOutput("lw_data", obs_ld, 32'hDEAD_BEEF);
        checkOutput("lw_busy", busy, 3);

        applyStimulus(1, 0, 3'b010, 32'h0000_4000, 32'h0);
        runAccess(0, 32'h0, busy, reqc);
        checkOutput("to_req_cycles", reqc, 4);
        checkOutput("to_bus_error", {31'h0, obs_berr}, 32'h1);
        checkOutput("to_load_data", obs_ld, 32'h0);

        applyStimulus(1, 0, 3'b010, 32'h0000_5000, 32'h0);
        @(negedge clk);
        checkOutput("rst_pre_req", {31'h0, mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        checkOutput("rst_async_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        #2;
        checkOutput("late_ack_busy", {31'h0, busywait}, 32'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        #2;
        checkOutput("late_ack_req", {31'h0, mem_req}, 32'h0);
        checkOutput("late_ack_load", load_data, 32'h0);

        applyStimulus(0, 0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage data-memory access unit, directly upstream of the MEM/WB pipeline register.
- Takes load/store controls, address and store data from EX/MEM and runs a request/acknowledge transaction with data memory.
- Returns aligned, sign/zero-extended load data to MEM/WB.
- Drives busywait, which stalls the whole pipeline (including MEM/WB) while an access is outstanding.

Parameters:
- TIMEOUT, 255, max cycles in WAIT before forced abort; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset: asserted when 0, async assert, sync release.
- mem_read  input  1  load request from EX/MEM.
- mem_write  input  1  store request from EX/MEM.
- funct3  input  3  access size/sign, RV32 encoding.
- addr  input  32  byte address (ALU result).
- store_data  input  32  rs2 value, LSB-justified.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word address, bits [1:0] = 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte enables; 0000 on reads.
- mem_ack  input  1  one-cycle completion pulse from memory.
- mem_rdata  input  32  read word, valid with mem_ack.
- load_data  output  32  extended load result to MEM/WB.
- busywait  output  1  pipeline stall.
- access_fault  output  1  misaligned or illegal access, combinational.
- bus_error  output  1  one-cycle pulse on timeout abort.

Behaviour:
- FSM states are IDLE, WAIT and DONE. Reset forces IDLE.
- Reset values: all registered outputs are 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, load_data, bus_error), and the timeout counter is 0.
- Request decode: access = mem_read | mem_write. If both are high, the access is a store.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any code other than 000, 001, 010.
- Misaligned:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
- access_fault = IDLE & access & (misaligned | illegal). When it is set, no request is issued, busywait = 0, and load_data is unchanged.
- IDLE -> WAIT on a legal access. At that edge the unit registers:
  - mem_req = 1, mem_we, mem_addr = {addr[31:2], 00}.
  - wdata/wstrb, plus addr[1:0] and funct3 for extraction.
  - Counter cleared.
- Store formatting:
  - SB: wdata = byte replicated x4, wstrb = 0001 << addr[1:0].
  - SH: wdata = half replicated x2, wstrb = 0011 or 1100 per addr[1].
  - SW: wdata = store_data, wstrb = 1111.
- In WAIT, mem_req and all mem_* outputs are held stable. The counter increments each cycle.
- WAIT -> DONE on mem_ack:
  - Clear mem_req, mem_we and mem_wstrb.
  - For loads, register the extracted load_data; stores leave load_data unchanged.
- Load extraction uses the registered addr[1:0]:
  - LB/LBU: byte lane addr[1:0], sign/zero extended.
  - LH/LHU: lane addr[1], sign/zero extended.
  - LW: full word.
- Timeout: in WAIT with TIMEOUT != 0 and counter == TIMEOUT-1 with no ack:
  - Go to DONE, drop mem_req, load_data = 0.
  - Pulse bus_error for 1 cycle, during DONE.
- DONE -> IDLE unconditionally. DONE lasts exactly one cycle, during which busywait = 0 so EX/MEM and MEM/WB advance and MEM/WB captures load_data.
- busywait = (IDLE & access & legal) | WAIT. It is combinational, so the stall begins in the same cycle the access appears.
- Latency: the minimum access is 3 cycles (IDLE detect, WAIT with ack, DONE). Back-to-back memory ops re-enter WAIT from IDLE on the cycle after DONE.
- The held EX/MEM instruction is not re-issued, because DONE -> IDLE coincides with pipeline advance.
- mem_ack while in IDLE or DONE is ignored.
- Reset mid-WAIT: mem_req drops immediately (async), FSM returns to IDLE, and a late ack after release is ignored.

Test Plan:
- LB at addr 0x0000_1003, mem_rdata 0x80FF_1234 -> mem_addr 0x0000_1000, wstrb 0000; DONE: load_data 0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH addr 0x0000_2002, store_data 0x0000_ABCD, ack after 3 WAIT cycles -> mem_we 1, wdata 0xABCD_ABCD, wstrb 1100, busywait high 4 cycles then low 1 cycle in DONE.
- LW addr 0x0000_1001 -> access_fault 1, busywait 0, mem_req never rises. funct3 011 load -> same.
- TIMEOUT=4, LW with no ack -> mem_req high 4 cycles, then bus_error pulse, load_data 0x0, FSM to IDLE.
- rst to 0 during WAIT -> mem_req 0 immediately; ack pulsed after release -> no state change, busywait 0.
- SW 0x0000_3000 data 0xDEAD_BEEF, then LW 0x0000_3000 with ack data 0xDEAD_BEEF -> two separate transactions with one IDLE cycle between, load_data 0xDEAD_BEEF.
